// File: rtl/sram_bus_ctrl.sv
// sram_bus_ctrl: turns the CPU's single-cycle req/ack data-memory handshake into
// sequenced strobes for an external asynchronous 256K x 16 SRAM.
//
// Ports:
//   clk, reset (async, active-low)
//   req, we, addr, wdata, be      - CPU request, sampled when ready=1
//   ready                         - combinational, high while idle
//   ack                           - one-cycle completion pulse
//   rdata                         - read data, held until the next read completes
//   sram_addr                     - SRAM address pins, changes only on accept
//   sram_ctl                      - {CE_N, OE_N, WE_N, UB_N, LB_N}, active-low
//   sram_dq                       - bidirectional SRAM data bus
module sram_bus_ctrl #(
    parameter int unsigned ADDR_W  = 18,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_WAIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        be,
    output logic              ready,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [4:0]        sram_ctl,
    inout  wire  [DATA_W-1:0] sram_dq
);

    localparam int unsigned CNT_MAX = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [4:0]  CTL_OFF = 5'b11111;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          be_q, be_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [4:0]          sram_ctl_q, sram_ctl_d;
    logic                dq_oe_q, dq_oe_d;
    logic                ack_q, ack_d;

    // Next-state, request capture and read-data capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sram_addr_d = sram_addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    sram_addr_d = addr;
                    wdata_d     = wdata;
                    be_d        = be;
                    if (be == 2'b00) begin
                        // No lanes selected: complete without touching the SRAM.
                        state_d = DONE;
                    end else if (we) begin
                        state_d = WR_SETUP;
                    end else begin
                        state_d = RD;
                        cnt_d   = CNT_W'(RD_WAIT - 1);
                    end
                end
            end
            RD: begin
                if (cnt_q == '0) begin
                    rdata_d = sram_dq;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = CNT_W'(WR_WAIT - 1);
            end
            WR_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_HOLD: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin values are decoded from the next state so they register on the same
    // edge as the state change.
    always_comb begin
        sram_ctl_d = CTL_OFF;
        dq_oe_d    = 1'b0;
        ack_d      = 1'b0;
        case (state_d)
            RD:       sram_ctl_d = {1'b0, 1'b0, 1'b1, ~be_d};
            WR_SETUP: begin
                sram_ctl_d = {1'b0, 1'b1, 1'b1, ~be_d};
                dq_oe_d    = 1'b1;
            end
            WR_PULSE: begin
                sram_ctl_d = {1'b0, 1'b1, 1'b0, ~be_d};
                dq_oe_d    = 1'b1;
            end
            WR_HOLD: begin
                sram_ctl_d = {1'b0, 1'b1, 1'b1, ~be_d};
                dq_oe_d    = 1'b1;
            end
            DONE:     ack_d = 1'b1;
            default:  ;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sram_addr_q <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rdata_q     <= '0;
            sram_ctl_q  <= CTL_OFF;
            dq_oe_q     <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sram_addr_q <= sram_addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rdata_q     <= rdata_d;
            sram_ctl_q  <= sram_ctl_d;
            dq_oe_q     <= dq_oe_d;
            ack_q       <= ack_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign sram_addr = sram_addr_q;
    assign sram_ctl  = sram_ctl_q;
    assign sram_dq   = dq_oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Self-checking bench for sram_bus_ctrl with a behavioural async SRAM model.
module tb_sram_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        ready;
    logic        ack;
    logic [15:0] rdata;
    logic [17:0] sram_addr;
    logic [4:0]  sram_ctl;
    wire  [15:0] sram_dq;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [0:262143];

    sram_bus_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .be        (be),
        .ready     (ready),
        .ack       (ack),
        .rdata     (rdata),
        .sram_addr (sram_addr),
        .sram_ctl  (sram_ctl),
        .sram_dq   (sram_dq)
    );

    always #5 clk = ~clk;

    // Released bus floats high, so an undriven bus reads 16'hFFFF.
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (sram_dq[i]);
    end

    // SRAM model: drives full word during a read, latches enabled lanes on WE_N rise.
    assign sram_dq = (!sram_ctl[4] && !sram_ctl[3] && sram_ctl[2]) ? mem[sram_addr] : 16'hzzzz;

    always @(posedge sram_ctl[2]) begin
        if (sram_ctl[4] == 1'b0) begin
            if (sram_ctl[1] == 1'b0) mem[sram_addr][15:8] = sram_dq[15:8];
            if (sram_ctl[0] == 1'b0) mem[sram_addr][7:0]  = sram_dq[7:0];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        w;
        logic [17:0] a;
        logic [15:0] d;
        logic [1:0]  b;
        int          lat;
        int          oe_c;
        int          we_c;
        int          drv_c;
        int          ce_c;
        int          ub_c;
        int          lb_c;
        logic [15:0] rd;
        logic [15:0] mem_exp;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [17:0] a, input logic [15:0] d,
                                input logic [1:0] b, input int lat, input int oe_c,
                                input int we_c, input int drv_c, input int ce_c,
                                input int ub_c, input int lb_c, input logic [15:0] rd,
                                input logic [15:0] mem_exp);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.b = b; v.lat = lat; v.oe_c = oe_c; v.we_c = we_c;
        v.drv_c = drv_c; v.ce_c = ce_c; v.ub_c = ub_c; v.lb_c = lb_c; v.rd = rd;
        v.mem_exp = mem_exp;
        return v;
    endfunction

    // One transaction: counts strobe cycles between accept and ack, then compares.
    task automatic run_txn(input vec_t v, input int idx);
        int n = 0;
        int ce = 0, oe = 0, wl = 0, ub = 0, lb = 0, drv = 0, bad = 0;
        bit got = 0;
        @(negedge clk);
        check($sformatf("v%0d_ready", idx), 32'(ready), 32'd1);
        req = 1'b1; we = v.w; addr = v.a; wdata = v.d; be = v.b;
        @(posedge clk);
        #1 req = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (ack) begin
                got = 1;
            end else begin
                if (!sram_ctl[4]) ce++;
                if (!sram_ctl[3]) oe++;
                if (!sram_ctl[2]) wl++;
                if (!sram_ctl[1]) ub++;
                if (!sram_ctl[0]) lb++;
                if (sram_ctl[3] && sram_dq !== 16'hFFFF) begin
                    drv++;
                    if (sram_dq !== v.d) bad++;
                end
            end
        end
        check($sformatf("v%0d_latency", idx), 32'(n), 32'(v.lat));
        check($sformatf("v%0d_done_ctl", idx), 32'(sram_ctl), 32'h1F);
        check($sformatf("v%0d_done_dq", idx), 32'(sram_dq), 32'hFFFF);
        check($sformatf("v%0d_ce_cycles", idx), 32'(ce), 32'(v.ce_c));
        check($sformatf("v%0d_oe_cycles", idx), 32'(oe), 32'(v.oe_c));
        check($sformatf("v%0d_we_cycles", idx), 32'(wl), 32'(v.we_c));
        check($sformatf("v%0d_ub_cycles", idx), 32'(ub), 32'(v.ub_c));
        check($sformatf("v%0d_lb_cycles", idx), 32'(lb), 32'(v.lb_c));
        check($sformatf("v%0d_drive_cycles", idx), 32'(drv), 32'(v.drv_c));
        check($sformatf("v%0d_drive_value", idx), 32'(bad), 32'd0);
        check($sformatf("v%0d_sram_addr", idx), 32'(sram_addr), 32'(v.a));
        if (!v.w) check($sformatf("v%0d_rdata", idx), 32'(rdata), 32'(v.rd));
        else      check($sformatf("v%0d_mem", idx), 32'(mem[v.a]), 32'(v.mem_exp));
    endtask

    vec_t vecs [8];

    initial begin
        int n;
        int acks;
        int first_ack;
        int second_ack;
        int last_drv;
        int first_oe;
        bit seen_we;

        vecs[0] = mk(0, 18'h000A5, 16'h0000, 2'b11, 3, 2, 0, 0, 2, 2, 2, 16'hBEEF, 16'h0);
        vecs[1] = mk(1, 18'h3FFFF, 16'h1234, 2'b11, 5, 0, 2, 4, 4, 4, 4, 16'h0, 16'h1234);
        vecs[2] = mk(1, 18'h00010, 16'hAA55, 2'b01, 5, 0, 2, 4, 4, 0, 4, 16'h0, 16'hFF55);
        vecs[3] = mk(0, 18'h00010, 16'h0000, 2'b11, 3, 2, 0, 0, 2, 2, 2, 16'hFF55, 16'h0);
        vecs[4] = mk(1, 18'h00020, 16'h1234, 2'b10, 5, 0, 2, 4, 4, 4, 0, 16'h0, 16'h1200);
        vecs[5] = mk(0, 18'h00020, 16'h0000, 2'b00, 1, 0, 0, 0, 0, 0, 0, 16'hFF55, 16'h0);
        vecs[6] = mk(0, 18'h00020, 16'h0000, 2'b10, 3, 2, 0, 0, 2, 2, 0, 16'h1200, 16'h0);
        vecs[7] = mk(1, 18'h00030, 16'hABCD, 2'b00, 1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h5555);

        mem[18'h000A5] = 16'hBEEF;
        mem[18'h3FFFF] = 16'h0000;
        mem[18'h00010] = 16'hFFFF;
        mem[18'h00020] = 16'h0000;
        mem[18'h00030] = 16'h5555;
        mem[18'h00001] = 16'h0000;
        mem[18'h00040] = 16'h0000;

        reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        repeat (2) @(negedge clk);
        check("rst_ctl", 32'(sram_ctl), 32'h1F);
        check("rst_dq", 32'(sram_dq), 32'hFFFF);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

        // Reset asserted while WE_N is low aborts the write immediately.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 18'h00040; wdata = 16'h7777; be = 2'b11;
        @(posedge clk);
        #1 req = 1'b0;
        seen_we = 0;
        for (int i = 0; i < 10 && !seen_we; i++) begin
            @(negedge clk);
            if (!sram_ctl[2]) seen_we = 1;
        end
        check("abort_we_low_seen", 32'(seen_we), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_ctl", 32'(sram_ctl), 32'h1F);
        check("abort_dq", 32'(sram_dq), 32'hFFFF);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_addr", 32'(sram_addr), 32'd0);
        acks = 0;
        repeat (2) begin
            @(negedge clk);
            if (ack) acks++;
        end
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (ack) acks++;
        end
        check("abort_no_ack", 32'(acks), 32'd0);
        check("abort_ready_after", 32'(ready), 32'd1);

        // Back-to-back write then read with req held high throughout.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 18'h00001; wdata = 16'h0F0F; be = 2'b11;
        @(posedge clk);
        n = 0; acks = 0; first_ack = 0; second_ack = 0; last_drv = 0; first_oe = 0;
        while (n < 16) begin
            @(negedge clk);
            n++;
            if (sram_ctl[3] && sram_dq !== 16'hFFFF) last_drv = n;
            if (!sram_ctl[3] && first_oe == 0) first_oe = n;
            if (ack) begin
                acks++;
                if (acks == 1) begin
                    first_ack = n;
                    we = 1'b0; wdata = 16'h0000;
                end else if (acks == 2) begin
                    second_ack = n;
                    req = 1'b0;
                    check("b2b_rdata", 32'(rdata), 32'h0F0F);
                end
            end
            if (first_ack != 0 && n == first_ack + 1) check("b2b_idle_ready", 32'(ready), 32'd1);
        end
        check("b2b_first_ack", 32'(first_ack), 32'd5);
        check("b2b_second_ack", 32'(second_ack), 32'd9);
        check("b2b_ack_count", 32'(acks), 32'd2);
        check("b2b_turnaround_ok", 32'((first_oe - last_drv - 1) >= 2), 32'd1);
        check("b2b_mem", 32'(mem[18'h00001]), 32'h0F0F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
